// File: rtl/ram_fifo_pkg.sv
// Shared constants and sizing helpers for the RAM-backed FWFT FIFO controller.
package ram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEPTH          = 1 << DEF_ADDR_WIDTH;
    localparam int OUTBUF_DEPTH   = 2;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic int level_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry register FIFO that catches RAM read data and presents the head word.
module ram_fifo_outbuf
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [1:0]            o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_data0;
    logic [DATA_WIDTH-1:0] r_data1;
    logic [1:0]            r_occ;

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_occ   <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_data0 <= i_push_data;
                    else               r_data1 <= i_push_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_data0 <= i_push_data;
                    end else begin
                        r_data0 <= r_data1;
                        r_data1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_data0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FWFT FIFO controller driving an external dual-port RAM (A = write, B = read)
// with a 2-entry output buffer hiding the RAM's registered read latency.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  full,
    output logic                  empty,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic                  ram_web,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic                  r_inflight;
    logic [ADDR_WIDTH+1:0] r_level;

    logic                  w_s_ready;
    logic                  w_wr;
    logic                  w_issue;
    logic                  w_pop;
    logic                  w_m_valid;
    logic [1:0]            w_occ;
    logic [2:0]            w_pend;
    logic [DATA_WIDTH-1:0] w_head;

    // ram_cnt never exceeds DEPTH, so its MSB alone marks the RAM region full.
    assign w_s_ready = !rst && !r_ram_cnt[ADDR_WIDTH];
    assign w_wr      = s_valid && w_s_ready;
    assign w_m_valid = !rst && (w_occ != 2'd0);
    assign w_pop     = w_m_valid && m_ready;
    assign w_pend    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue   = !rst && (r_ram_cnt != '0) && (w_pend < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_level    <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + {{ADDR_WIDTH{1'b0}}, w_wr};
            r_rd_ptr   <= r_rd_ptr + {{ADDR_WIDTH{1'b0}}, w_issue};
            r_ram_cnt  <= r_ram_cnt + {{ADDR_WIDTH{1'b0}}, w_wr}
                                    - {{ADDR_WIDTH{1'b0}}, w_issue};
            r_inflight <= w_issue;
            r_level    <= r_level + {{(ADDR_WIDTH+1){1'b0}}, w_wr}
                                  - {{(ADDR_WIDTH+1){1'b0}}, w_pop};
        end
    end

    ram_fifo_outbuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outbuf (
        .clk        (clk),
        .rst        (rst),
        .i_push     (r_inflight),
        .i_push_data(ram_doutb),
        .i_pop      (w_pop),
        .o_occ      (w_occ),
        .o_head     (w_head)
    );

    assign s_ready   = w_s_ready;
    assign m_valid   = w_m_valid;
    assign m_data    = w_head;
    assign level     = rst ? '0 : r_level;
    assign full      = !rst && r_ram_cnt[ADDR_WIDTH];
    assign empty     = (level == '0);

    assign ram_ena   = w_wr;
    assign ram_wea   = w_wr;
    assign ram_addra = r_wr_ptr[ADDR_WIDTH-1:0];
    assign ram_dina  = s_data;
    assign ram_enb   = w_issue;
    assign ram_web   = 1'b0;
    assign ram_addrb = r_rd_ptr[ADDR_WIDTH-1:0];

endmodule
